sync_inserter_v2: RTL

SYNC_INSERTER_V2 -- requirements
Module: sync_inserter_v2

---
 rtl/sync_inserter_v2.sv | 197 +++++++++++++++++++
 1 files changed

// File: rtl/sync_inserter_v2.sv
// Frames an 8-bit payload stream into 32-bit words: repeated sync marker, fixed-length
// payload, then pad bytes, with a single-register valid/ready output stage.
module sync_inserter_v2 #(
    parameter logic [63:0] SYNC_MARKER     = 64'hB1699558_A53333A8,
    parameter int unsigned SYNC_REPETITION = 3,
    parameter int unsigned PAYLOAD_LEN     = 255,
    parameter logic [7:0]  PAD_BYTE        = 8'h00
) (
    input  logic        core_clk,
    input  logic        rst,
    input  logic [7:0]  s_axis_tdata,
    input  logic        s_axis_tvalid,
    input  logic        s_axis_tlast,
    output logic        s_axis_tready,
    output logic [31:0] data_o,
    output logic        data_valid_o,
    input  logic        data_ready_i,
    output logic        start_of_frame_o,
    output logic        len_err_o,
    output logic [15:0] frame_cnt_o
);

    localparam int unsigned PADDING_LEN = (4 - ((8 * SYNC_REPETITION + PAYLOAD_LEN) % 4)) % 4;
    localparam int unsigned BODY_LEN    = PAYLOAD_LEN + PADDING_LEN;
    localparam int unsigned SYNC_WORDS  = 2 * SYNC_REPETITION;
    localparam int unsigned BW          = (BODY_LEN > 1) ? $clog2(BODY_LEN) : 1;
    localparam int unsigned WW          = (SYNC_WORDS > 1) ? $clog2(SYNC_WORDS) : 1;

    localparam logic [BW-1:0] LAST_PAY  = BW'(PAYLOAD_LEN - 1);
    localparam logic [BW:0]   BODY_END  = (BW + 1)'(BODY_LEN);
    localparam logic [WW-1:0] LAST_SYNC = WW'(SYNC_WORDS - 1);
    localparam logic [31:0]   PAD_WORD  = {4{PAD_BYTE}};

    typedef enum logic [1:0] {IDLE, SYNC, PAYLOAD, FILL} state_t;

    state_t        state_q, state_d;
    logic [WW-1:0] wcnt_q, wcnt_d;
    logic [BW-1:0] bcnt_q, bcnt_d;
    logic [31:0]   pack_q, pack_d;
    logic [31:0]   data_q, data_d;
    logic          valid_q, valid_d;
    logic          last_q, last_d;
    logic          sof_q, sof_d;
    logic          len_err_q, len_err_d;
    logic [15:0]   frame_cnt_q, frame_cnt_d;

    logic          accept, out_free, waiting, frame_end;
    logic          final_byte, completes, tready, byte_acc, at_body_end;
    logic [1:0]    slot;
    logic [BW:0]   nxt_align;
    logic [31:0]   word_in, marker_word;

    assign accept      = valid_q & data_ready_i;
    assign out_free    = ~valid_q | data_ready_i;
    // The frame's final word is in the output register: stall input until it drains.
    assign waiting     = valid_q & last_q;
    assign frame_end   = accept & last_q;
    assign slot        = bcnt_q[1:0];
    assign final_byte  = (bcnt_q == LAST_PAY);
    assign completes   = (slot == 2'd3) | final_byte | s_axis_tlast;
    assign tready      = (state_q == PAYLOAD) & ~waiting & (out_free | ~completes);
    assign byte_acc    = s_axis_tvalid & tready;
    assign nxt_align   = {1'b0, bcnt_q[BW-1:2], 2'b00} + (BW + 1)'(4);
    assign at_body_end = (nxt_align == BODY_END);
    assign marker_word = wcnt_q[0] ? SYNC_MARKER[31:0] : SYNC_MARKER[63:32];

    // pack_q is refilled with pad bytes after each word, so unfilled slots are already padded.
    always_comb begin
        word_in = pack_q;
        case (slot)
            2'd0:    word_in[31:24] = s_axis_tdata;
            2'd1:    word_in[23:16] = s_axis_tdata;
            2'd2:    word_in[15:8]  = s_axis_tdata;
            default: word_in[7:0]   = s_axis_tdata;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        wcnt_d      = wcnt_q;
        bcnt_d      = bcnt_q;
        pack_d      = pack_q;
        data_d      = data_q;
        valid_d     = valid_q & ~data_ready_i;
        last_d      = last_q;
        sof_d       = sof_q;
        len_err_d   = 1'b0;
        frame_cnt_d = frame_cnt_q + 16'(frame_end);

        case (state_q)
            IDLE: begin
                if (s_axis_tvalid) begin
                    state_d = SYNC;
                    wcnt_d  = '0;
                end
            end
            SYNC: begin
                if (out_free) begin
                    data_d  = marker_word;
                    valid_d = 1'b1;
                    last_d  = 1'b0;
                    sof_d   = (wcnt_q == '0);
                    if (wcnt_q == LAST_SYNC) begin
                        state_d = PAYLOAD;
                        bcnt_d  = '0;
                    end else begin
                        wcnt_d = wcnt_q + 1'b1;
                    end
                end
            end
            PAYLOAD: begin
                if (byte_acc) begin
                    if (completes) begin
                        data_d  = word_in;
                        valid_d = 1'b1;
                        last_d  = at_body_end;
                        sof_d   = 1'b0;
                        pack_d  = PAD_WORD;
                        if (final_byte) begin
                            len_err_d = ~s_axis_tlast;
                            bcnt_d    = '0;
                        end else if (s_axis_tlast) begin
                            len_err_d = 1'b1;
                            state_d   = FILL;
                            bcnt_d    = at_body_end ? '0 : nxt_align[BW-1:0];
                        end else begin
                            bcnt_d = bcnt_q + 1'b1;
                        end
                    end else begin
                        pack_d = word_in;
                        bcnt_d = bcnt_q + 1'b1;
                    end
                end
            end
            FILL: begin
                if (!waiting && out_free) begin
                    data_d  = PAD_WORD;
                    valid_d = 1'b1;
                    last_d  = at_body_end;
                    sof_d   = 1'b0;
                    bcnt_d  = nxt_align[BW-1:0];
                end
            end
            default: state_d = IDLE;
        endcase

        // Next frame's first marker loads in the same cycle the last word drains: no bubble.
        if (frame_end) begin
            bcnt_d = '0;
            if (s_axis_tvalid) begin
                state_d = SYNC;
                data_d  = SYNC_MARKER[63:32];
                valid_d = 1'b1;
                last_d  = 1'b0;
                sof_d   = 1'b1;
                wcnt_d  = WW'(1);
            end else begin
                state_d = IDLE;
                wcnt_d  = '0;
            end
        end
    end

    always_ff @(posedge core_clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            wcnt_q      <= '0;
            bcnt_q      <= '0;
            pack_q      <= PAD_WORD;
            data_q      <= '0;
            valid_q     <= 1'b0;
            last_q      <= 1'b0;
            sof_q       <= 1'b0;
            len_err_q   <= 1'b0;
            frame_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            wcnt_q      <= wcnt_d;
            bcnt_q      <= bcnt_d;
            pack_q      <= pack_d;
            data_q      <= data_d;
            valid_q     <= valid_d;
            last_q      <= last_d;
            sof_q       <= sof_d;
            len_err_q   <= len_err_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

    assign s_axis_tready    = tready;
    assign data_o           = data_q;
    assign data_valid_o     = valid_q;
    assign start_of_frame_o = accept & sof_q;
    assign len_err_o        = len_err_q;
    assign frame_cnt_o      = frame_cnt_q;

endmodule
